sc_mtimer: RTL and testbench
============================

Name: sc_mtimer

Overview:
- Multi-channel, parametrised successor to the game's single free-running time counter.
- CHANNELS independent up-counters share one clock and one prescaler. Each channel has a programmable period, a periodic or one-shot mode, an enable and a clear, and produces a one-cycle tick plus a sticky done flag.
- Drives the game's frog/lane speed timing and the level timeout from one block. The selected channel's count is readable on one bus.

Parameters:
- CHANNELS, 4, number of independent timer channels (1..16).
- WIDTH, 24, width of each channel's count and period.
- PRESCALE, 1, clock cycles per count advance, shared by all channels (1..2^16).
- ADDRW, 2, channel-select width; must satisfy 2^ADDRW >= CHANNELS.

Ports:
- SC_MTIMER_CLOCK_50  in  1  system clock.
- SC_MTIMER_RESET_InLow  in  1  synchronous, active-low reset.
- SC_MTIMER_Write_InHigh  in  1  period/mode write strobe for channel Addr.
- SC_MTIMER_Addr_InBUS  in  ADDRW  channel select for write and read.
- SC_MTIMER_Period_InBUS  in  WIDTH  period value written on Write.
- SC_MTIMER_Mode_InHigh  in  1  mode written on Write: 1 = periodic, 0 = one-shot.
- SC_MTIMER_Enable_InBUS  in  CHANNELS  per-channel count enable, level.
- SC_MTIMER_Clear_InBUS  in  CHANNELS  per-channel synchronous clear, active high.
- SC_MTIMER_Tick_OutBUS  out  CHANNELS  one-cycle pulse at period expiry.
- SC_MTIMER_Done_OutBUS  out  CHANNELS  sticky one-shot expiry flag.
- SC_MTIMER_data_OutBUS  out  WIDTH  count of the channel selected by Addr.

Behaviour:
- Reset: on a rising clock edge with RESET_InLow = 0, the following all go to 0: prescaler, every count, period, mode, Tick and Done.
  - Reset mid-operation aborts all channels.
  - After reset, every channel is idle (period 0) until it is rewritten.
- Prescaler: free-running 0..PRESCALE-1.
  - adv = 1 in the cycle where the prescaler equals PRESCALE-1. When PRESCALE = 1, adv is constantly 1.
  - The prescaler is unaffected by channel clear, enable or write.
- Per-channel priority on each edge: reset > Clear > Write > advance.
- Clear[i]: count <= 0, Done[i] <= 0, Tick[i] <= 0. Period and mode are kept. A Write to the same channel in the same cycle is dropped.
- Write to channel i (Addr < CHANNELS): period <= Period_InBUS, mode <= Mode_InHigh, count <= 0, Done <= 0. No advance occurs in that cycle.
- Write with Addr >= CHANNELS: ignored.
- Advance condition: Enable[i] & adv & !Done[i] & (period != 0).
  - If count != period-1: count <= count+1.
  - If count == period-1: Tick[i] <= 1 for exactly the next cycle.
    - Periodic mode: count <= 0.
    - One-shot mode: count <= period and Done[i] <= 1; the count then holds until Clear or Write.
- Tick spacing in periodic mode is exactly period advances, i.e. period x PRESCALE clocks while enabled.
- Tick is registered. In every cycle with no expiry it is 0.
- Enable low: count holds and no tick is generated; re-enabling resumes from the held count.
- Period 0: the channel never advances or ticks, and the count stays 0.
- Wrap: period 2^WIDTH-1 is legal. The count never exceeds period, so there is no arithmetic overflow.
- Read: data_OutBUS = count[Addr], combinational from registers. It is 0 when Addr >= CHANNELS.
- No latency beyond one clock from any input to the affected register.

Decomposition:
- Package sc_mtimer_pkg holds:
  - MODE_ONESHOT = 1'b0 and MODE_PERIODIC = 1'b1;
  - default WIDTH and CHANNELS constants;
  - a log2 helper function for ADDRW and prescaler sizing.
- Sub-module sc_mtimer_channel holds one channel's count, period, mode, Tick and Done logic. The top instantiates CHANNELS copies via generate, owns the prescaler, decodes Addr, and muxes the read bus.

Test Plan:
- Reset: drive RESET_InLow = 0 for 2 clocks during activity -> Tick = 0, Done = 0, data = 0 for all Addr; Enable alone then produces no ticks.
- Periodic: CHANNELS=4, PRESCALE=1; write ch0 period 5 periodic, Enable[0] = 1 -> data reads 1,2,3,4,0,1...; Tick[0] is high for one cycle following each 4->0 step, every 5 clocks; other channels stay 0.
- One-shot: write ch1 period 3 one-shot, enable -> single Tick[1] pulse, Done[1] = 1, count holds 3 for 20+ clocks; rewriting ch1 -> Done[1] = 0, count = 0.
- Enable/clear: at ch0 count 2, drop Enable[0] for 4 clocks -> count stays 2; re-enable -> 3; assert Clear[0] together with a Write to ch0 -> count 0, old period retained.
- Prescaler: PRESCALE=4, period 2 periodic -> count steps every 4 clocks, Tick every 8 clocks.
- Boundaries: period 0 write -> no tick in 100 clocks; Addr = 3 with CHANNELS=3 -> write ignored, read 0; WIDTH=4, period 15 -> Tick every 15 clocks, count never exceeds 14.

Source files
------------

// File: rtl/sc_mtimer_pkg.sv
// Shared types and constants for the multi-channel timer.
// Imported by the interface, the channel and the top.
package sc_mtimer_pkg;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  localparam int DEF_WIDTH    = 24;
  localparam int DEF_CHANNELS = 4;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/sc_mtimer_if.sv
// Control/status bus of sc_mtimer: write port, per-channel enables/clears,
// tick/done flags and the read-back count.
interface sc_mtimer_if
  import sc_mtimer_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDRW    = clog2_min1(DEF_CHANNELS)
);

  logic                SC_MTIMER_Write_InHigh;
  logic [ADDRW-1:0]    SC_MTIMER_Addr_InBUS;
  logic [WIDTH-1:0]    SC_MTIMER_Period_InBUS;
  logic                SC_MTIMER_Mode_InHigh;
  logic [CHANNELS-1:0] SC_MTIMER_Enable_InBUS;
  logic [CHANNELS-1:0] SC_MTIMER_Clear_InBUS;
  logic [CHANNELS-1:0] SC_MTIMER_Tick_OutBUS;
  logic [CHANNELS-1:0] SC_MTIMER_Done_OutBUS;
  logic [WIDTH-1:0]    SC_MTIMER_data_OutBUS;

  modport master (
    output SC_MTIMER_Write_InHigh, SC_MTIMER_Addr_InBUS, SC_MTIMER_Period_InBUS,
           SC_MTIMER_Mode_InHigh, SC_MTIMER_Enable_InBUS, SC_MTIMER_Clear_InBUS,
    input  SC_MTIMER_Tick_OutBUS, SC_MTIMER_Done_OutBUS, SC_MTIMER_data_OutBUS
  );

  modport slave (
    input  SC_MTIMER_Write_InHigh, SC_MTIMER_Addr_InBUS, SC_MTIMER_Period_InBUS,
           SC_MTIMER_Mode_InHigh, SC_MTIMER_Enable_InBUS, SC_MTIMER_Clear_InBUS,
    output SC_MTIMER_Tick_OutBUS, SC_MTIMER_Done_OutBUS, SC_MTIMER_data_OutBUS
  );

endinterface

// File: rtl/sc_mtimer_channel.sv
// One timer channel: count, period, mode, registered tick and sticky done.
// Priority per edge: reset > clear > write > advance.
module sc_mtimer_channel
  import sc_mtimer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             SC_MTIMER_CHANNEL_CLOCK_50,
  input  logic             SC_MTIMER_CHANNEL_RESET_InLow,
  input  logic             SC_MTIMER_CHANNEL_Write_InHigh,
  input  logic [WIDTH-1:0] SC_MTIMER_CHANNEL_Period_InBUS,
  input  logic             SC_MTIMER_CHANNEL_Mode_InHigh,
  input  logic             SC_MTIMER_CHANNEL_Enable_InHigh,
  input  logic             SC_MTIMER_CHANNEL_Clear_InHigh,
  input  logic             SC_MTIMER_CHANNEL_Adv_InHigh,
  output logic             SC_MTIMER_CHANNEL_Tick_OutHigh,
  output logic             SC_MTIMER_CHANNEL_Done_OutHigh,
  output logic [WIDTH-1:0] SC_MTIMER_CHANNEL_Count_OutBUS
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] period_q;
  mode_e            mode_q;
  logic             tick_q;
  logic             done_q;
  logic             step;

  assign step = SC_MTIMER_CHANNEL_Enable_InHigh & SC_MTIMER_CHANNEL_Adv_InHigh &
                ~done_q & (period_q != '0);

  // NOTE: every register here is written with <= so all of them see the
  // pre-edge values of each other, whatever order the branches appear in.
  always_ff @(posedge SC_MTIMER_CHANNEL_CLOCK_50) begin
    if (!SC_MTIMER_CHANNEL_RESET_InLow) begin
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (SC_MTIMER_CHANNEL_Clear_InHigh) begin
        count_q <= '0;
        done_q  <= 1'b0;
      end else if (SC_MTIMER_CHANNEL_Write_InHigh) begin
        period_q <= SC_MTIMER_CHANNEL_Period_InBUS;
        mode_q   <= mode_e'(SC_MTIMER_CHANNEL_Mode_InHigh);
        count_q  <= '0;
        done_q   <= 1'b0;
      end else if (step) begin
        if (count_q == period_q - ONE) begin
          tick_q <= 1'b1;
          // One-shot parks at period so the count reads as "fully elapsed".
          if (mode_q == MODE_PERIODIC) begin
            count_q <= '0;
          end else begin
            count_q <= period_q;
            done_q  <= 1'b1;
          end
        end else begin
          count_q <= count_q + ONE;
        end
      end
    end
  end

  assign SC_MTIMER_CHANNEL_Tick_OutHigh = tick_q;
  assign SC_MTIMER_CHANNEL_Done_OutHigh = done_q;
  assign SC_MTIMER_CHANNEL_Count_OutBUS = count_q;

endmodule

// File: rtl/sc_mtimer.sv
// Multi-channel timer: shared prescaler, CHANNELS independent up-counters,
// address-decoded period/mode writes and a muxed count read-back.
module sc_mtimer
  import sc_mtimer_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = 1,
  parameter int ADDRW    = clog2_min1(CHANNELS)
) (
  input  logic       SC_MTIMER_CLOCK_50,
  input  logic       SC_MTIMER_RESET_InLow,
  sc_mtimer_if.slave bus
);

  logic                adv;
  logic [CHANNELS-1:0] write_sel;
  logic [CHANNELS-1:0] tick_w;
  logic [CHANNELS-1:0] done_w;
  logic [WIDTH-1:0]    count_w [CHANNELS];
  logic [WIDTH-1:0]    data_w;

  // Prescaler runs regardless of channel activity; only reset touches it.
  generate
    if (PRESCALE > 1) begin : g_psc
      localparam int             PSW      = clog2_min1(PRESCALE);
      localparam logic [PSW-1:0] PSC_LAST = PSW'(PRESCALE - 1);
      logic [PSW-1:0] psc_q;

      always_ff @(posedge SC_MTIMER_CLOCK_50) begin
        if (!SC_MTIMER_RESET_InLow) begin
          psc_q <= '0;
        end else if (psc_q == PSC_LAST) begin
          psc_q <= '0;
        end else begin
          psc_q <= psc_q + PSW'(1);
        end
      end

      assign adv = (psc_q == PSC_LAST);
    end else begin : g_no_psc
      assign adv = 1'b1;
    end
  endgenerate

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign write_sel[i] = bus.SC_MTIMER_Write_InHigh &
                          (bus.SC_MTIMER_Addr_InBUS == ADDRW'(i));

    sc_mtimer_channel #(.WIDTH(WIDTH)) u_channel (
      .SC_MTIMER_CHANNEL_CLOCK_50      (SC_MTIMER_CLOCK_50),
      .SC_MTIMER_CHANNEL_RESET_InLow   (SC_MTIMER_RESET_InLow),
      .SC_MTIMER_CHANNEL_Write_InHigh  (write_sel[i]),
      .SC_MTIMER_CHANNEL_Period_InBUS  (bus.SC_MTIMER_Period_InBUS),
      .SC_MTIMER_CHANNEL_Mode_InHigh   (bus.SC_MTIMER_Mode_InHigh),
      .SC_MTIMER_CHANNEL_Enable_InHigh (bus.SC_MTIMER_Enable_InBUS[i]),
      .SC_MTIMER_CHANNEL_Clear_InHigh  (bus.SC_MTIMER_Clear_InBUS[i]),
      .SC_MTIMER_CHANNEL_Adv_InHigh    (adv),
      .SC_MTIMER_CHANNEL_Tick_OutHigh  (tick_w[i]),
      .SC_MTIMER_CHANNEL_Done_OutHigh  (done_w[i]),
      .SC_MTIMER_CHANNEL_Count_OutBUS  (count_w[i])
    );
  end

  // NOTE: data_w gets a default before the loop so an unmatched address
  // (Addr >= CHANNELS) reads 0 instead of inferring a latch.
  always_comb begin
    data_w = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.SC_MTIMER_Addr_InBUS == ADDRW'(i)) data_w = count_w[i];
    end
  end

  assign bus.SC_MTIMER_Tick_OutBUS = tick_w;
  assign bus.SC_MTIMER_Done_OutBUS = done_w;
  assign bus.SC_MTIMER_data_OutBUS = data_w;

endmodule

// File: tb/tb_sc_mtimer.sv
// Bench for sc_mtimer: three configurations share one stimulus stream and are
// compared every cycle against a behavioural model, plus directed scenarios.
module tb_sc_mtimer;
  import sc_mtimer_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        st_rst_n;
  logic        st_write;
  logic [1:0]  st_addr;
  logic [23:0] st_period;
  logic        st_mode;
  logic [3:0]  st_en;
  logic [3:0]  st_clear;

  // A: 4ch/24b/psc1, B: 3ch/4b/psc4, C: 3ch/4b/psc1
  sc_mtimer_if #(.CHANNELS(4), .WIDTH(24), .ADDRW(2)) if_a ();
  sc_mtimer_if #(.CHANNELS(3), .WIDTH(4),  .ADDRW(2)) if_b ();
  sc_mtimer_if #(.CHANNELS(3), .WIDTH(4),  .ADDRW(2)) if_c ();

  assign if_a.SC_MTIMER_Write_InHigh = st_write;
  assign if_a.SC_MTIMER_Addr_InBUS   = st_addr;
  assign if_a.SC_MTIMER_Period_InBUS = st_period;
  assign if_a.SC_MTIMER_Mode_InHigh  = st_mode;
  assign if_a.SC_MTIMER_Enable_InBUS = st_en;
  assign if_a.SC_MTIMER_Clear_InBUS  = st_clear;

  assign if_b.SC_MTIMER_Write_InHigh = st_write;
  assign if_b.SC_MTIMER_Addr_InBUS   = st_addr;
  assign if_b.SC_MTIMER_Period_InBUS = st_period[3:0];
  assign if_b.SC_MTIMER_Mode_InHigh  = st_mode;
  assign if_b.SC_MTIMER_Enable_InBUS = st_en[2:0];
  assign if_b.SC_MTIMER_Clear_InBUS  = st_clear[2:0];

  assign if_c.SC_MTIMER_Write_InHigh = st_write;
  assign if_c.SC_MTIMER_Addr_InBUS   = st_addr;
  assign if_c.SC_MTIMER_Period_InBUS = st_period[3:0];
  assign if_c.SC_MTIMER_Mode_InHigh  = st_mode;
  assign if_c.SC_MTIMER_Enable_InBUS = st_en[2:0];
  assign if_c.SC_MTIMER_Clear_InBUS  = st_clear[2:0];

  sc_mtimer #(.CHANNELS(4), .WIDTH(24), .PRESCALE(1), .ADDRW(2)) u_dut_a (
    .SC_MTIMER_CLOCK_50(clk), .SC_MTIMER_RESET_InLow(st_rst_n), .bus(if_a.slave));
  sc_mtimer #(.CHANNELS(3), .WIDTH(4), .PRESCALE(4), .ADDRW(2)) u_dut_b (
    .SC_MTIMER_CLOCK_50(clk), .SC_MTIMER_RESET_InLow(st_rst_n), .bus(if_b.slave));
  sc_mtimer #(.CHANNELS(3), .WIDTH(4), .PRESCALE(1), .ADDRW(2)) u_dut_c (
    .SC_MTIMER_CLOCK_50(clk), .SC_MTIMER_RESET_InLow(st_rst_n), .bus(if_c.slave));

  logic [3:0]  g_tick [ND];
  logic [3:0]  g_done [ND];
  logic [23:0] g_data [ND];
  assign g_tick[0] = if_a.SC_MTIMER_Tick_OutBUS;
  assign g_tick[1] = {1'b0, if_b.SC_MTIMER_Tick_OutBUS};
  assign g_tick[2] = {1'b0, if_c.SC_MTIMER_Tick_OutBUS};
  assign g_done[0] = if_a.SC_MTIMER_Done_OutBUS;
  assign g_done[1] = {1'b0, if_b.SC_MTIMER_Done_OutBUS};
  assign g_done[2] = {1'b0, if_c.SC_MTIMER_Done_OutBUS};
  assign g_data[0] = if_a.SC_MTIMER_data_OutBUS;
  assign g_data[1] = {20'd0, if_b.SC_MTIMER_data_OutBUS};
  assign g_data[2] = {20'd0, if_c.SC_MTIMER_data_OutBUS};

  string names [ND] = '{"A", "B", "C"};
  int    nch   [ND] = '{4, 3, 3};
  int    ps    [ND] = '{1, 4, 1};
  int    wmask [ND] = '{32'h00FF_FFFF, 32'h0000_000F, 32'h0000_000F};

  // Model state: elapsed advances in the current period, period, mode, flags.
  int m_cnt  [ND][4];
  int m_per  [ND][4];
  bit m_per_mode [ND][4];
  bit m_tick [ND][4];
  bit m_done [ND][4];
  int m_clk_since_rst [ND];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      bit adv;
      if (!st_rst_n) begin
        m_clk_since_rst[d] = 0;
        for (int i = 0; i < 4; i++) begin
          m_cnt[d][i] = 0; m_per[d][i] = 0; m_per_mode[d][i] = 0;
          m_tick[d][i] = 0; m_done[d][i] = 0;
        end
        continue;
      end
      // Advance on the last clock of every PRESCALE-clock group since reset.
      adv = ((m_clk_since_rst[d] % ps[d]) == ps[d] - 1);
      m_clk_since_rst[d]++;
      for (int i = 0; i < nch[d]; i++) begin
        m_tick[d][i] = 0;
        if (st_clear[i]) begin
          m_cnt[d][i] = 0; m_done[d][i] = 0;
        end else if (st_write && int'(st_addr) == i) begin
          m_per[d][i] = int'(st_period) & wmask[d];
          m_per_mode[d][i] = st_mode;
          m_cnt[d][i] = 0; m_done[d][i] = 0;
        end else if (st_en[i] && adv && !m_done[d][i] && m_per[d][i] != 0) begin
          if (m_cnt[d][i] + 1 == m_per[d][i]) begin
            m_tick[d][i] = 1;
            if (m_per_mode[d][i]) m_cnt[d][i] = 0;
            else begin m_cnt[d][i] = m_per[d][i]; m_done[d][i] = 1; end
          end else begin
            m_cnt[d][i]++;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      logic [31:0] et, ed, ev;
      et = 0; ed = 0;
      for (int i = 0; i < nch[d]; i++) begin
        if (m_tick[d][i]) et |= (32'd1 << i);
        if (m_done[d][i]) ed |= (32'd1 << i);
      end
      ev = (int'(st_addr) < nch[d]) ? m_cnt[d][st_addr] : 0;
      check($sformatf("%s.tick@%0d", names[d], cyc), {28'd0, g_tick[d]}, et);
      check($sformatf("%s.done@%0d", names[d], cyc), {28'd0, g_done[d]}, ed);
      check($sformatf("%s.data@%0d", names[d], cyc), {8'd0, g_data[d]}, ev);
    end
  endtask

  task automatic write_ch(input int ch, input int per, input bit md);
    st_write = 1'b1; st_addr = 2'(ch); st_period = 24'(per); st_mode = md;
    step();
    st_write = 1'b0;
  endtask

  initial begin
    int ticks, last, maxv;
    st_rst_n = 1'b0; st_write = 1'b0; st_addr = '0; st_period = '0;
    st_mode = 1'b0; st_en = '0; st_clear = '0;
    repeat (3) step();
    check("rst_tick", {28'd0, g_tick[0]}, 0);
    check("rst_done", {28'd0, g_done[0]}, 0);
    st_rst_n = 1'b1;

    // Periodic, period 5 on ch0
    write_ch(0, 5, MODE_PERIODIC);
    st_en = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("per5_data%0d", k), {8'd0, g_data[0]}, (k + 1) % 5);
      check($sformatf("per5_tick%0d", k), {28'd0, g_tick[0]}, (k % 5 == 4) ? 1 : 0);
    end

    // Enable hold, then clear colliding with a write
    repeat (2) step();
    st_en = 4'b0000;
    repeat (4) step();
    check("hold_data", {8'd0, g_data[0]}, 2);
    st_en = 4'b0001;
    step();
    check("resume_data", {8'd0, g_data[0]}, 3);
    st_clear = 4'b0001;
    write_ch(0, 7, MODE_PERIODIC);
    st_clear = 4'b0000;
    check("clr_data", {8'd0, g_data[0]}, 0);
    repeat (4) step();
    check("clr_keep4", {8'd0, g_data[0]}, 4);
    step();
    check("clr_keep_wrap", {8'd0, g_data[0]}, 0);
    check("clr_keep_tick", {31'd0, g_tick[0][0]}, 1);

    // One-shot, period 3 on ch1
    write_ch(1, 3, MODE_ONESHOT);
    st_en = 4'b0011; st_addr = 2'd1;
    ticks = 0;
    repeat (25) begin step(); if (g_tick[0][1]) ticks++; end
    check("oneshot_ticks", ticks, 1);
    check("oneshot_done", {31'd0, g_done[0][1]}, 1);
    check("oneshot_hold", {8'd0, g_data[0]}, 3);
    write_ch(1, 3, MODE_ONESHOT);
    check("rewrite_done", {31'd0, g_done[0][1]}, 0);
    check("rewrite_data", {8'd0, g_data[0]}, 0);

    // Mid-operation reset
    st_rst_n = 1'b0;
    repeat (2) step();
    st_rst_n = 1'b1; st_en = 4'b1111;
    for (int a = 0; a < 4; a++) begin
      st_addr = 2'(a);
      step();
      check($sformatf("post_rst_data%0d", a), {8'd0, g_data[0]}, 0);
    end
    ticks = 0;
    repeat (20) begin step(); if (g_tick[0] != 0) ticks++; end
    check("post_rst_noticks", ticks, 0);

    // Prescaler 4 on B: period 2 -> tick every 8 clocks
    st_en = 4'b0000;
    write_ch(0, 2, MODE_PERIODIC);
    st_en = 4'b0001; st_addr = 2'd0;
    ticks = 0; last = -1;
    repeat (40) begin
      step();
      if (g_tick[1][0]) begin
        if (last >= 0) check("psc_interval", cyc - last, 8);
        last = cyc; ticks++;
      end
    end
    check("psc_nticks", (ticks >= 4) ? 1 : 0, 1);

    // Period 0 never ticks
    write_ch(2, 0, MODE_PERIODIC);
    st_en = 4'b0100;
    ticks = 0;
    repeat (100) begin step(); if (g_tick[0][2]) ticks++; end
    check("per0_noticks", ticks, 0);

    // Addr 3 on 3-channel builds is ignored and reads 0
    write_ch(3, 9, MODE_PERIODIC);
    st_en = 4'b1111; st_addr = 2'd3;
    repeat (5) step();
    check("addr3_read_b", {8'd0, g_data[1]}, 0);
    check("addr3_read_c", {8'd0, g_data[2]}, 0);

    // WIDTH=4 full period on C
    write_ch(2, 15, MODE_PERIODIC);
    st_en = 4'b0100; st_addr = 2'd2;
    ticks = 0; last = -1; maxv = 0;
    repeat (60) begin
      step();
      if (int'(g_data[2]) > maxv) maxv = int'(g_data[2]);
      if (g_tick[2][2]) begin
        if (last >= 0) check("w4_interval", cyc - last, 15);
        last = cyc; ticks++;
      end
    end
    check("w4_max", maxv, 14);
    check("w4_nticks", (ticks >= 3) ? 1 : 0, 1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int k;
      st_rst_n = ($urandom_range(0, 299) != 0);
      st_write = ($urandom_range(0, 19) == 0);
      st_addr  = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 9);
      st_period = (k < 8) ? 24'($urandom_range(0, 9)) :
                  (k == 8) ? 24'hFF_FFFF : 24'($urandom);
      st_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 3);
        st_en[k] = ~st_en[k];
      end
      for (int i = 0; i < 4; i++) st_clear[i] = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
